// File: rtl/copro_result_buffer_pkg.sv
// Shared constants and helpers for the coprocessor result stage.
// No logic of its own; sizes counters and the register-address field.
// Imported by the result FIFO and the result buffer top.
package copro_result_buffer_pkg;

    // Destination register address width (x0..x31)
    localparam int unsigned RegAddrW = 5;

    // Default result data width
    localparam int unsigned DefXlen = 32;

    // Occupancy counters need one extra bit so that "full" (== Depth) is representable
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/copro_result_fifo.sv
// Depth-entry circular FIFO holding coprocessor result entries.
// Latency: a push is visible at head_o the cycle after the write edge; no bypass.
// Backpressure: a push while full is ignored unless a pop happens in the same cycle.
module copro_result_fifo
    import copro_result_buffer_pkg::*;
#(
    parameter type         entry_t = logic,
    parameter int unsigned Depth   = 4,
    localparam int unsigned PtrW   = $clog2(Depth),
    localparam int unsigned CntW   = cnt_width(Depth)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            push_i,
    input  entry_t          push_data_i,
    input  logic            pop_i,
    output entry_t          head_o,
    output logic            full_o,
    output logic            empty_o,
    output logic [CntW-1:0] count_o
);

    entry_t            mem_q [Depth];
    logic [PtrW-1:0]   wr_ptr_q;
    logic [PtrW-1:0]   rd_ptr_q;
    logic [CntW-1:0]   count_q;
    logic              pop_ok;
    logic              push_ok;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);

    // Storage: write at wr_ptr; cleared on reset so stale data never leaks out
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Pointers wrap naturally because Depth is a power of two
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
        end
    end

    // Occupancy: simultaneous push and pop leaves the count unchanged
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/copro_result_buffer.sv
// Buffers ALU result beats and presents them on the CV-X-IF result channel; runs issue credits.
// Latency: beat at cycle N appears on result_valid_o at N+1; no bypass path.
// Backpressure: result_ready_i stalls the head; ALU cannot stall, so beats arriving while full are dropped and flagged.
module copro_result_buffer
    import copro_result_buffer_pkg::*;
#(
    parameter int unsigned  XLEN     = DefXlen,
    parameter int unsigned  Depth    = 4,
    parameter type          hartid_t = logic,
    parameter type          id_t     = logic,
    localparam int unsigned CntW     = cnt_width(Depth)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    // Issue-side credits
    input  logic                alloc_i,
    output logic                space_avail_o,
    // ALU result beat
    input  logic                alu_valid_i,
    input  logic [XLEN-1:0]     alu_result_i,
    input  hartid_t             alu_hartid_i,
    input  id_t                 alu_id_i,
    input  logic [RegAddrW-1:0] alu_rd_i,
    input  logic                alu_we_i,
    // CV-X-IF result channel
    output logic                result_valid_o,
    input  logic                result_ready_i,
    output logic [XLEN-1:0]     result_data_o,
    output hartid_t             result_hartid_o,
    output id_t                 result_id_o,
    output logic [RegAddrW-1:0] result_rd_o,
    output logic                result_we_o,
    // Status
    output logic [CntW-1:0]     count_o,
    output logic                overflow_o
);

    typedef struct packed {
        logic [XLEN-1:0]     data;
        hartid_t             hartid;
        id_t                 id;
        logic [RegAddrW-1:0] rd;
        logic                we;
    } copro_result_t;

    copro_result_t     push_entry;
    copro_result_t     head_entry;
    copro_result_t     out_entry;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic [CntW-1:0]   count;
    logic [CntW-1:0]   reserved_q;
    logic [CntW:0]     occupancy;
    logic              credit_inc;
    logic              credit_dec;
    logic              overflow_q;

    assign push_entry = '{data:   alu_result_i,
                          hartid: alu_hartid_i,
                          id:     alu_id_i,
                          rd:     alu_rd_i,
                          we:     alu_we_i};

    assign result_valid_o = ~fifo_empty;
    assign pop            = result_valid_o & result_ready_i;

    copro_result_fifo #(
        .entry_t (copro_result_t),
        .Depth   (Depth)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (alu_valid_i),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (head_entry),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (count)
    );

    assign count_o = count;

    // Head fields are forced to zero whenever nothing is being offered
    always_comb begin
        out_entry = '0;
        if (result_valid_o) out_entry = head_entry;
    end

    assign result_data_o   = out_entry.data;
    assign result_hartid_o = out_entry.hartid;
    assign result_id_o     = out_entry.id;
    assign result_rd_o     = out_entry.rd;
    assign result_we_o     = out_entry.we;

    // Space is derived from registered state only, so issue_ready has no path from this cycle's inputs
    assign occupancy     = {1'b0, count} + {1'b0, reserved_q};
    assign space_avail_o = (occupancy < (CntW+1)'(Depth));

    // An alloc without space is ignored; a beat only retires a credit if one is outstanding
    assign credit_inc = alloc_i & space_avail_o;
    assign credit_dec = alu_valid_i & (reserved_q != '0);

    // Reservation counter: alloc and beat in the same cycle cancel
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            reserved_q <= '0;
        end else if (credit_inc && !credit_dec) begin
            reserved_q <= reserved_q + CntW'(1);
        end else if (credit_dec && !credit_inc) begin
            reserved_q <= reserved_q - CntW'(1);
        end
    end

    // Sticky overflow: a beat arrived while full and the head did not leave
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overflow_q <= 1'b0;
        end else if (alu_valid_i && fifo_full && !pop) begin
            overflow_q <= 1'b1;
        end
    end

    assign overflow_o = overflow_q;

endmodule
